timer_seq: RTL and testbench

TIMER_SEQ -- requirements
Module: timer_seq

---
 rtl/timer_seq.sv | 194 +++++++++++++++++++
 tb/tb_timer_seq.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_seq.sv
// timer_seq: programs a bus-attached timer (EXPR, COUNTER, CTRL), services expiry
// interrupts and counts them. Define TIMER_SEQ_TIMEOUT_EN to add a bus-transfer timeout.
module timer_seq #(
    parameter int TO_CYCLES = 16,
    parameter int TICK_W    = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              stop,
    input  logic [31:0]       period,
    input  logic              periodic,
    output logic              cs_,
    output logic              as_,
    output logic              rw,
    output logic [1:0]        addr,
    output logic [31:0]       wr_data,
    input  logic              rdy_,
    input  logic              irq,
    output logic              busy,
    output logic              tick,
    output logic [TICK_W-1:0] tick_cnt,
    output logic              err
);

    typedef enum logic [2:0] {
        IDLE,
        WR_EXPR,
        WR_CNT,
        WR_CTRL,
        RUN,
        CLR_IRQ,
        STOP
    } state_t;

    localparam logic [1:0] ADDR_CTRL    = 2'd0;
    localparam logic [1:0] ADDR_INTR    = 2'd1;
    localparam logic [1:0] ADDR_EXPR    = 2'd2;
    localparam logic [1:0] ADDR_COUNTER = 2'd3;

    if (TO_CYCLES < 1) begin : g_bad_to_cycles
        $error("timer_seq: TO_CYCLES must be at least 1");
    end
    if (TICK_W < 1) begin : g_bad_tick_w
        $error("timer_seq: TICK_W must be at least 1");
    end

    state_t      state;
    state_t      state_next;
    logic        xfer_done;
    logic        xfer_done_next;
    logic        stop_pend;
    logic        stop_pend_next;
    logic        stop_req;
    logic        tick_next;
    logic [31:0] period_q;
    logic        periodic_q;
    logic        is_write;
    logic        strobe;
    logic        accept;
    logic        timeout;

    // States in which a stop has to wait for the current transfer to finish.
    function automatic logic defers_stop(input state_t s);
        return (s == WR_EXPR) || (s == WR_CNT) || (s == WR_CTRL) || (s == CLR_IRQ);
    endfunction

    // Each write state has a strobe phase and, once rdy_ is seen, one idle completion cycle.
    assign is_write = defers_stop(state) || (state == STOP);
    assign strobe   = is_write && !xfer_done;
    assign accept   = strobe && !rdy_;
    assign stop_req = stop_pend || stop;

    assign cs_  = !strobe;
    assign as_  = !strobe;
    assign rw   = 1'b0;
    assign busy = (state != IDLE);

`ifdef TIMER_SEQ_TIMEOUT_EN
    localparam int TO_W = $clog2(TO_CYCLES + 1);

    logic [TO_W-1:0] to_cnt;

    // Counts strobe cycles without rdy_; a transfer that hits the limit is abandoned.
    assign timeout = strobe && rdy_ && (to_cnt == TO_W'(TO_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            to_cnt <= '0;
            err    <= 1'b0;
        end else begin
            if (strobe && rdy_ && !timeout) begin
                to_cnt <= to_cnt + TO_W'(1);
            end else begin
                to_cnt <= '0;
            end
            if (timeout) begin
                err <= 1'b1;
            end
        end
    end
`else
    assign timeout = 1'b0;
    assign err     = 1'b0;
`endif

    always_comb begin
        state_next     = state;
        xfer_done_next = 1'b0;
        tick_next      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = WR_EXPR;
                end
            end
            RUN: begin
                if (stop) begin
                    state_next = STOP;
                end else if (irq) begin
                    state_next = CLR_IRQ;
                end
            end
            default: begin
                if (timeout) begin
                    state_next = IDLE;
                end else if (!xfer_done) begin
                    xfer_done_next = accept;
                end else begin
                    case (state)
                        WR_EXPR: state_next = stop_req ? STOP : WR_CNT;
                        WR_CNT:  state_next = stop_req ? STOP : WR_CTRL;
                        WR_CTRL: state_next = stop_req ? STOP : RUN;
                        CLR_IRQ: begin
                            tick_next = 1'b1;
                            if (stop_req) begin
                                state_next = STOP;
                            end else begin
                                state_next = periodic_q ? RUN : IDLE;
                            end
                        end
                        default: state_next = IDLE;
                    endcase
                end
            end
        endcase

        stop_pend_next = 1'b0;
        if (defers_stop(state) && defers_stop(state_next)) begin
            stop_pend_next = stop_pend || stop;
        end
    end

    always_comb begin
        addr    = ADDR_CTRL;
        wr_data = '0;
        case (state)
            WR_EXPR: begin
                addr    = ADDR_EXPR;
                wr_data = period_q;
            end
            WR_CNT:  addr = ADDR_COUNTER;
            WR_CTRL: wr_data = {30'b0, periodic_q, 1'b1};
            CLR_IRQ: addr = ADDR_INTR;
            default: ;
        endcase
    end

    // tick is registered so it coincides with the updated tick_cnt.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            xfer_done  <= 1'b0;
            stop_pend  <= 1'b0;
            period_q   <= '0;
            periodic_q <= 1'b0;
            tick       <= 1'b0;
            tick_cnt   <= '0;
        end else begin
            state     <= state_next;
            xfer_done <= xfer_done_next;
            stop_pend <= stop_pend_next;
            tick      <= tick_next;
            if (tick_next) begin
                tick_cnt <= tick_cnt + TICK_W'(1);
            end
            if ((state == IDLE) && start) begin
                period_q   <= period;
                periodic_q <= periodic;
            end
        end
    end

endmodule

// File: tb/tb_timer_seq.sv
// tb_timer_seq: directed vectors for timer_seq with a bus slave model that answers
// one cycle after the strobe and logs every accepted write.
module tb_timer_seq;
    localparam int TO_CYCLES = 16;
    localparam int TICK_W    = 4;

    logic              clk;
    logic              reset;
    logic              start;
    logic              stop;
    logic [31:0]       period;
    logic              periodic;
    logic              cs_;
    logic              as_;
    logic              rw;
    logic [1:0]        addr;
    logic [31:0]       wr_data;
    logic              rdy_;
    logic              irq;
    logic              busy;
    logic              tick;
    logic [TICK_W-1:0] tick_cnt;
    logic              err;

    int          n_vec = 0;
    int          n_miss = 0;
    logic [1:0]  log_addr [0:255];
    logic [31:0] log_data [0:255];
    int          log_n = 0;
    int          ticks_seen = 0;
    int          strobe_cycles = 0;
    int          strobe_age = 0;
    logic        slave_en = 1'b1;
    int          base;
    int          t0;
    int          sc0;

    timer_seq #(
        .TO_CYCLES(TO_CYCLES),
        .TICK_W   (TICK_W)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .stop    (stop),
        .period  (period),
        .periodic(periodic),
        .cs_     (cs_),
        .as_     (as_),
        .rw      (rw),
        .addr    (addr),
        .wr_data (wr_data),
        .rdy_    (rdy_),
        .irq     (irq),
        .busy    (busy),
        .tick    (tick),
        .tick_cnt(tick_cnt),
        .err     (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Slave answers on the second strobe cycle; rdy_ seen low here is accepted at the next edge.
    initial begin
        rdy_ = 1'b1;
        forever begin
            @(negedge clk);
            if (!cs_ && !as_ && slave_en) begin
                rdy_ = (strobe_age >= 1) ? 1'b0 : 1'b1;
                strobe_age++;
            end else begin
                rdy_ = 1'b1;
                strobe_age = 0;
            end
            if (!cs_ && !as_) strobe_cycles++;
            if (!cs_ && !as_ && !rdy_ && !reset && log_n < 256) begin
                log_addr[log_n] = addr;
                log_data[log_n] = wr_data;
                log_n++;
            end
            if (tick) ticks_seen++;
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got no finish, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic checkWrite(input int idx, input string tag, input logic [1:0] a, input logic [31:0] d);
        checkOutput({tag, "_addr"}, {30'b0, log_addr[idx]}, {30'b0, a});
        checkOutput({tag, "_data"}, log_data[idx], d);
    endtask

    task automatic applyStimulus(input logic s, input logic p, input logic i,
                                 input logic [31:0] per, input logic per_m);
        @(negedge clk);
        start    = s;
        stop     = p;
        irq      = i;
        period   = per;
        periodic = per_m;
        @(negedge clk);
        start = 1'b0;
        stop  = 1'b0;
        irq   = 1'b0;
    endtask

    task automatic applyReset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic waitWrites(input int n, input int max_cyc, input string tag);
        int k = 0;
        while (log_n < n && k < max_cyc) begin
            @(negedge clk);
            k++;
        end
        if (log_n < n) checkOutput({tag, "_wr_wait"}, log_n, n);
    endtask

    task automatic waitIdle(input int max_cyc, input string tag);
        int k = 0;
        while (busy && k < max_cyc) begin
            @(negedge clk);
            k++;
        end
        if (busy) checkOutput({tag, "_idle_wait"}, {31'b0, busy}, 0);
    endtask

    task automatic waitTicks(input int n, input int max_cyc, input string tag);
        int k = 0;
        while (ticks_seen < n && k < max_cyc) begin
            @(negedge clk);
            k++;
        end
        if (ticks_seen < n) checkOutput({tag, "_tick_wait"}, ticks_seen, n);
    endtask

    task automatic waitStrobe(input logic [1:0] a, input int max_cyc, input string tag);
        int k = 0;
        while (!(!cs_ && addr == a) && k < max_cyc) begin
            @(negedge clk);
            k++;
        end
        if (!(!cs_ && addr == a)) checkOutput({tag, "_strobe_wait"}, {30'b0, addr}, {30'b0, a});
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; stop = 1'b0; irq = 1'b0;
        period = '0; periodic = 1'b0;

        applyReset();
        checkOutput("rst_cs", {31'b0, cs_}, 1);
        checkOutput("rst_as", {31'b0, as_}, 1);
        checkOutput("rst_rw", {31'b0, rw}, 0);
        checkOutput("rst_addr", {30'b0, addr}, 0);
        checkOutput("rst_wdata", wr_data, 0);
        checkOutput("rst_tick", {31'b0, tick}, 0);
        checkOutput("rst_tick_cnt", {28'b0, tick_cnt}, 0);
        checkOutput("rst_err", {31'b0, err}, 0);
        checkOutput("rst_busy", {31'b0, busy}, 0);

        // One-shot programming and a single serviced expiry.
        base = log_n; t0 = ticks_seen;
        applyStimulus(1, 0, 0, 32'd100, 0);
        checkOutput("t1_busy", {31'b0, busy}, 1);
        waitWrites(base + 3, 40, "t1");
        repeat (3) @(negedge clk);
        checkWrite(base,     "t1_expr", 2'd2, 32'd100);
        checkWrite(base + 1, "t1_cnt",  2'd3, 32'd0);
        checkWrite(base + 2, "t1_ctrl", 2'd0, 32'h1);
        checkOutput("t1_run_busy", {31'b0, busy}, 1);
        checkOutput("t1_run_cnt", {28'b0, tick_cnt}, 0);
        applyStimulus(0, 0, 1, 32'd100, 0);
        waitIdle(40, "t1");
        repeat (2) @(negedge clk);
        checkWrite(base + 3, "t1_intr", 2'd1, 32'd0);
        checkOutput("t1_nwr", log_n - base, 4);
        checkOutput("t1_ticks", ticks_seen - t0, 1);
        checkOutput("t1_tick_cnt", {28'b0, tick_cnt}, 1);

        // Periodic mode stays in RUN across several expiries.
        applyReset();
        base = log_n; t0 = ticks_seen;
        applyStimulus(1, 0, 0, 32'd5, 1);
        waitWrites(base + 3, 40, "t2");
        repeat (3) @(negedge clk);
        checkWrite(base,     "t2_expr", 2'd2, 32'd5);
        checkWrite(base + 2, "t2_ctrl", 2'd0, 32'h3);
        for (int i = 1; i <= 3; i++) begin
            applyStimulus(0, 0, 1, 32'd5, 1);
            waitTicks(t0 + i, 40, "t2");
            repeat (2) @(negedge clk);
            checkOutput($sformatf("t2_busy_%0d", i), {31'b0, busy}, 1);
        end
        checkOutput("t2_ticks", ticks_seen - t0, 3);
        checkOutput("t2_tick_cnt", {28'b0, tick_cnt}, 3);
        checkOutput("t2_nwr", log_n - base, 6);
        applyStimulus(0, 1, 0, 32'd5, 1);
        waitIdle(40, "t2");
        repeat (2) @(negedge clk);
        checkWrite(base + 6, "t2_stop", 2'd0, 32'd0);
        checkOutput("t2_cnt_kept", {28'b0, tick_cnt}, 3);

        // stop while idle does nothing.
        base = log_n;
        applyStimulus(0, 1, 0, 32'd0, 0);
        repeat (2) @(negedge clk);
        checkOutput("idle_stop_busy", {31'b0, busy}, 0);
        checkOutput("idle_stop_nwr", log_n - base, 0);

        // stop during WR_CNT: transfer completes, then CTRL=0 instead of WR_CTRL.
        base = log_n;
        applyStimulus(1, 0, 0, 32'd7, 0);
        waitStrobe(2'd3, 40, "t3");
        checkOutput("t3_rw", {31'b0, rw}, 0);
        checkOutput("t3_cnt_data", wr_data, 0);
        applyStimulus(0, 1, 0, 32'd7, 0);
        waitIdle(60, "t3");
        repeat (2) @(negedge clk);
        checkOutput("t3_nwr", log_n - base, 3);
        checkWrite(base,     "t3_expr", 2'd2, 32'd7);
        checkWrite(base + 1, "t3_cnt",  2'd3, 32'd0);
        checkWrite(base + 2, "t3_stop", 2'd0, 32'd0);

        // irq and stop together in RUN: stop wins.
        base = log_n; t0 = ticks_seen;
        applyStimulus(1, 0, 0, 32'd9, 0);
        waitWrites(base + 3, 40, "t4");
        repeat (3) @(negedge clk);
        applyStimulus(0, 1, 1, 32'd9, 0);
        waitIdle(40, "t4");
        repeat (2) @(negedge clk);
        checkOutput("t4_nwr", log_n - base, 4);
        checkWrite(base + 3, "t4_stop", 2'd0, 32'd0);
        checkOutput("t4_ticks", ticks_seen - t0, 0);
        checkOutput("t4_tick_cnt", {28'b0, tick_cnt}, 3);

        // stop during CLR_IRQ: the tick is still emitted, then STOP.
        base = log_n; t0 = ticks_seen;
        applyStimulus(1, 0, 0, 32'd3, 1);
        waitWrites(base + 3, 40, "t7");
        repeat (3) @(negedge clk);
        applyStimulus(0, 0, 1, 32'd3, 1);
        waitStrobe(2'd1, 40, "t7");
        applyStimulus(0, 1, 0, 32'd3, 1);
        waitIdle(60, "t7");
        repeat (2) @(negedge clk);
        checkOutput("t7_nwr", log_n - base, 5);
        checkWrite(base + 3, "t7_intr", 2'd1, 32'd0);
        checkWrite(base + 4, "t7_stop", 2'd0, 32'd0);
        checkOutput("t7_ticks", ticks_seen - t0, 1);
        checkOutput("t7_tick_cnt", {28'b0, tick_cnt}, 4);

        // period=0, start while busy ignored, tick_cnt wraps after 16 expiries.
        applyReset();
        base = log_n; t0 = ticks_seen;
        applyStimulus(1, 0, 0, 32'd0, 1);
        waitWrites(base + 3, 40, "t5");
        repeat (3) @(negedge clk);
        checkWrite(base,     "t5_expr", 2'd2, 32'd0);
        checkWrite(base + 2, "t5_ctrl", 2'd0, 32'h3);
        applyStimulus(1, 0, 0, 32'hDEAD, 0);
        repeat (4) @(negedge clk);
        checkOutput("t5_busy_start_nwr", log_n - base, 3);
        checkOutput("t5_busy_start_busy", {31'b0, busy}, 1);
        for (int i = 1; i <= 16; i++) begin
            applyStimulus(0, 0, 1, 32'hDEAD, 0);
            waitTicks(t0 + i, 40, "t5");
            repeat (2) @(negedge clk);
            if (i == 15) checkOutput("t5_cnt_15", {28'b0, tick_cnt}, 15);
        end
        checkOutput("t5_wrap", {28'b0, tick_cnt}, 0);
        checkOutput("t5_ticks", ticks_seen - t0, 16);
        checkOutput("t5_still_run", {31'b0, busy}, 1);
        applyStimulus(0, 1, 0, 32'd0, 0);
        waitIdle(40, "t5");
        repeat (2) @(negedge clk);
        checkOutput("t5_nwr", log_n - base, 20);
        checkWrite(base + 19, "t5_stop", 2'd0, 32'd0);

        // Reset in the middle of a transfer drops the strobe at once.
        base = log_n;
        applyStimulus(1, 0, 0, 32'h44, 0);
        waitStrobe(2'd2, 40, "t8");
        reset = 1'b1;
        @(negedge clk);
        checkOutput("t8_cs", {31'b0, cs_}, 1);
        checkOutput("t8_as", {31'b0, as_}, 1);
        checkOutput("t8_addr", {30'b0, addr}, 0);
        checkOutput("t8_wdata", wr_data, 0);
        checkOutput("t8_busy", {31'b0, busy}, 0);
        reset = 1'b0;
        checkOutput("t8_nwr", log_n - base, 0);

        // Slave never answers.
        slave_en = 1'b0;
        sc0 = strobe_cycles;
        applyStimulus(1, 0, 0, 32'h55, 0);
`ifdef TIMER_SEQ_TIMEOUT_EN
        waitIdle(100, "t9");
        repeat (2) @(negedge clk);
        checkOutput("t9_strobes", strobe_cycles - sc0, TO_CYCLES);
        checkOutput("t9_err", {31'b0, err}, 1);
        checkOutput("t9_cs", {31'b0, cs_}, 1);
        repeat (3) @(negedge clk);
        checkOutput("t9_err_sticky", {31'b0, err}, 1);
        applyReset();
        checkOutput("t9_err_clr", {31'b0, err}, 0);
`else
        repeat (40) @(negedge clk);
        checkOutput("t9_hang_cs", {31'b0, cs_}, 0);
        checkOutput("t9_hang_addr", {30'b0, addr}, 2);
        checkOutput("t9_hang_data", wr_data, 32'h55);
        checkOutput("t9_err", {31'b0, err}, 0);
        applyReset();
        checkOutput("t9_reset_cs", {31'b0, cs_}, 1);
`endif
        slave_en = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
